token_drop_ctrl: RTL and testbench

Move-execution stage of the Connect Four datapath: accepts a column selection from the input/turn logic, finds the lowest empty cell in that column, writes the current player's code, and toggles the turn. Its registered `board` output is the `board` input of the win checker, and that checker's `juego_terminado` is fed back here to lock out further moves. It also tracks the move count and flags a full board (draw).

---
 rtl/connect4_pkg.sv | 16 +
 rtl/token_drop_ctrl_if.sv | 11 +
 rtl/token_drop_ctrl.sv | 170 +++++++++++++++++
 tb/tb_token_drop_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/connect4_pkg.sv
// Shared Connect Four definitions: board geometry, cell codes and the board type
// used by both the move-execution stage and the win checker.
package connect4_pkg;

    localparam int ROWS = 6;
    localparam int COLS = 7;

    localparam logic [2:0] CELL_EMPTY = 3'b000;
    localparam logic [2:0] CELL_P1    = 3'b001;
    localparam logic [2:0] CELL_P2    = 3'b010;
    localparam logic [2:0] CELL_WIN   = 3'b011;

    // board[row][col], row 0 at the top
    typedef logic [ROWS-1:0][COLS-1:0][2:0] board_t;

endpackage

// File: rtl/token_drop_ctrl_if.sv
// Move request handshake between the input/turn logic (master) and token_drop_ctrl (slave).
interface token_drop_ctrl_if;

    logic       move_valid;
    logic [2:0] move_col;
    logic       move_ready;

    modport master (output move_valid, output move_col, input move_ready);
    modport slave  (input move_valid, input move_col, output move_ready);

endinterface

// File: rtl/token_drop_ctrl.sv
// Connect Four move execution: scans the selected column bottom-up, commits the current
// player's token and toggles the turn. Optional drop animation: TOKEN_DROP_ANIM_EN.
//
// state  | meaning
// IDLE   | waiting for a move; move_ready high unless game over or board full
// SCAN   | testing one row per cycle, bottom row first, for the first empty cell
// FALL   | animation overlay stepping fall_row 0..r (TOKEN_DROP_ANIM_EN only)
// PLACE  | write token, toggle turn, bump move count, pulse move_done
// REJECT | invalid or full column; pulse move_reject, nothing else changes
module token_drop_ctrl
    import connect4_pkg::*;
#(
    parameter int ROWS        = connect4_pkg::ROWS,
    parameter int COLS        = connect4_pkg::COLS,
    parameter int FALL_CYCLES = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    token_drop_ctrl_if.slave                   mv,
    input  logic                               juego_terminado,
    output logic [ROWS-1:0][COLS-1:0][2:0]     board,
    output logic                               turn,
    output logic                               move_done,
    output logic                               move_reject,
    output logic [2:0]                         placed_row,
    output logic                               tablero_lleno,
    output logic                               fall_active,
    output logic [2:0]                         fall_row,
    output logic [2:0]                         fall_col
);

    localparam int CNT_W = $clog2(ROWS*COLS + 1);

    if (ROWS < 1 || ROWS > 8 || COLS < 1 || COLS > 8 || FALL_CYCLES < 1) begin : g_bad_params
        $error("token_drop_ctrl: ROWS/COLS must be 1..8 and FALL_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_PLACE  = 3'd2,
        S_REJECT = 3'd3
`ifdef TOKEN_DROP_ANIM_EN
        ,S_FALL  = 3'd4
`endif
    } state_t;

    state_t             state, state_nxt;
    logic [2:0]         col_q;
    logic [2:0]         scan_row;
    logic [2:0]         scan_cell;
    logic               cell_empty;
    logic               accept;
    logic [CNT_W-1:0]   move_cnt;

    assign mv.move_ready = !rst && (state == S_IDLE) && !juego_terminado && !tablero_lleno;
    assign accept        = mv.move_valid && mv.move_ready;
    assign scan_cell     = board[scan_row][col_q];
    assign cell_empty    = (scan_cell == CELL_EMPTY);

`ifdef TOKEN_DROP_ANIM_EN
    localparam int HOLD_W = $clog2(FALL_CYCLES + 1);

    logic [HOLD_W-1:0]  hold_cnt;
    logic [2:0]         fall_row_q;
    logic               fall_last;

    assign fall_last   = (hold_cnt == '0) && (fall_row_q == scan_row);
    assign fall_active = (state == S_FALL);
    assign fall_row    = fall_active ? fall_row_q : 3'd0;
    assign fall_col    = fall_active ? col_q : 3'd0;
`else
    assign fall_active = 1'b0;
    assign fall_row    = 3'd0;
    assign fall_col    = 3'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = (int'(mv.move_col) >= COLS) ? S_REJECT : S_SCAN;
            end
            S_SCAN: begin
                if (cell_empty) begin
`ifdef TOKEN_DROP_ANIM_EN
                    state_nxt = S_FALL;
`else
                    state_nxt = S_PLACE;
`endif
                end else if (scan_row == 3'd0) begin
                    state_nxt = S_REJECT;
                end
            end
`ifdef TOKEN_DROP_ANIM_EN
            S_FALL: begin
                if (fall_last) state_nxt = S_PLACE;
            end
`endif
            S_PLACE:  state_nxt = S_IDLE;
            S_REJECT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            board         <= '0;
            turn          <= 1'b0;
            move_done     <= 1'b0;
            move_reject   <= 1'b0;
            placed_row    <= 3'd0;
            tablero_lleno <= 1'b0;
            move_cnt      <= '0;
            col_q         <= 3'd0;
            scan_row      <= 3'd0;
`ifdef TOKEN_DROP_ANIM_EN
            hold_cnt      <= '0;
            fall_row_q    <= 3'd0;
`endif
        end else begin
            move_done   <= 1'b0;
            move_reject <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        col_q    <= mv.move_col;
                        scan_row <= 3'(ROWS - 1);
                    end
                end
                S_SCAN: begin
                    // scan_row stops on the first empty row and is reused as the target row
                    if (!cell_empty && scan_row != 3'd0) scan_row <= scan_row - 3'd1;
`ifdef TOKEN_DROP_ANIM_EN
                    if (cell_empty) begin
                        fall_row_q <= 3'd0;
                        hold_cnt   <= HOLD_W'(FALL_CYCLES - 1);
                    end
`endif
                end
`ifdef TOKEN_DROP_ANIM_EN
                S_FALL: begin
                    if (hold_cnt == '0) begin
                        hold_cnt <= HOLD_W'(FALL_CYCLES - 1);
                        if (fall_row_q != scan_row) fall_row_q <= fall_row_q + 3'd1;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
`endif
                S_PLACE: begin
                    board[scan_row][col_q] <= turn ? CELL_P2 : CELL_P1;
                    placed_row             <= scan_row;
                    turn                   <= ~turn;
                    move_cnt               <= move_cnt + 1'b1;
                    move_done              <= 1'b1;
                    if (move_cnt == CNT_W'(ROWS*COLS - 1)) tablero_lleno <= 1'b1;
                end
                S_REJECT: move_reject <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_token_drop_ctrl.sv
// Directed self-checking bench for token_drop_ctrl: vector table plus multi-cycle sequences.
module tb_token_drop_ctrl;
    import connect4_pkg::*;

    localparam int FC = 2;
`ifdef TOKEN_DROP_ANIM_EN
    localparam int ANIM = 1;
`else
    localparam int ANIM = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       juego_terminado = 1'b0;
    board_t     board;
    logic       turn, move_done, move_reject, tablero_lleno, fall_active;
    logic [2:0] placed_row, fall_row, fall_col;

    token_drop_ctrl_if mif();

    token_drop_ctrl #(.ROWS(ROWS), .COLS(COLS), .FALL_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .mv(mif), .juego_terminado(juego_terminado),
        .board(board), .turn(turn), .move_done(move_done), .move_reject(move_reject),
        .placed_row(placed_row), .tablero_lleno(tablero_lleno),
        .fall_active(fall_active), .fall_row(fall_row), .fall_col(fall_col)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    board_t model_board;
    logic   model_turn;

    typedef struct {
        logic [2:0] col;
        logic       exp_done;
        int         exp_lat;
        logic [2:0] exp_row;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Sends one move and waits for its pulse; also audits the fall overlay while waiting.
    task automatic do_move(input logic [2:0] col, input logic jt_after,
                           output logic done, output logic rej, output int lat,
                           output int fcyc, output int ferr);
        bit seen;
        @(negedge clk);
        mif.move_valid = 1'b1;
        mif.move_col   = col;
        @(posedge clk);
        #1;
        mif.move_valid  = 1'b0;
        juego_terminado = jt_after;
        done = 1'b0; rej = 1'b0; lat = 0; fcyc = 0; ferr = 0; seen = 1'b0;
        for (int i = 1; i <= 200 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (fall_active) begin
                if (fall_row != 3'(fcyc / FC) || fall_col != col || board != model_board) ferr++;
                fcyc++;
            end else if (fall_row != 3'd0 || fall_col != 3'd0) begin
                ferr++;
            end
            if (move_done || move_reject) begin
                seen = 1'b1;
                done = move_done;
                rej  = move_reject;
                lat  = i;
            end
        end
    endtask

    task automatic run_move(input string tag, input logic [2:0] col, input logic exp_done,
                            input int base_lat, input logic [2:0] exp_row, input logic jt_after);
        logic done, rej;
        int   lat, fcyc, ferr, exp_fall;
        exp_fall = exp_done ? ANIM * (int'(exp_row) + 1) * FC : 0;
        do_move(col, jt_after, done, rej, lat, fcyc, ferr);
        check({tag, ".done"}, done, exp_done);
        check({tag, ".reject"}, rej, !exp_done);
        check({tag, ".latency"}, lat, base_lat + exp_fall);
        check({tag, ".fall_cycles"}, fcyc, exp_fall);
        check({tag, ".fall_err"}, ferr, 0);
        if (exp_done) begin
            model_board[exp_row][col] = model_turn ? CELL_P2 : CELL_P1;
            model_turn = ~model_turn;
            check({tag, ".placed_row"}, placed_row, exp_row);
        end
        check({tag, ".board"}, board, model_board);
        check({tag, ".turn"}, turn, model_turn);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_board = '0;
        model_turn  = 1'b0;
    endtask

    initial begin
        int pulses;
        mif.move_valid = 1'b0;
        mif.move_col   = 3'd0;
        model_board    = '0;
        model_turn     = 1'b0;

        vecs[0]  = '{3'd3, 1'b1, 2, 3'd5};
        vecs[1]  = '{3'd3, 1'b1, 3, 3'd4};
        vecs[2]  = '{3'd7, 1'b0, 1, 3'd0};
        vecs[3]  = '{3'd0, 1'b1, 2, 3'd5};
        vecs[4]  = '{3'd0, 1'b1, 3, 3'd4};
        vecs[5]  = '{3'd0, 1'b1, 4, 3'd3};
        vecs[6]  = '{3'd0, 1'b1, 5, 3'd2};
        vecs[7]  = '{3'd0, 1'b1, 6, 3'd1};
        vecs[8]  = '{3'd0, 1'b1, 7, 3'd0};
        vecs[9]  = '{3'd0, 1'b0, ROWS + 1, 3'd0};
        vecs[10] = '{3'd6, 1'b1, 2, 3'd5};

        // reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst.ready_low", mif.move_ready, 1'b0);
        check("rst.board", board, '0);
        check("rst.turn", turn, 1'b0);
        check("rst.pulses", {move_done, move_reject}, 2'b00);
        check("rst.placed_row", placed_row, 3'd0);
        check("rst.lleno", tablero_lleno, 1'b0);
        check("rst.fall", {fall_active, fall_row, fall_col}, 7'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.ready_after", mif.move_ready, 1'b1);

        for (int v = 0; v < 11; v++) begin
            run_move($sformatf("vec%0d", v), vecs[v].col, vecs[v].exp_done,
                     vecs[v].exp_lat, vecs[v].exp_row, 1'b0);
            check($sformatf("vec%0d.ready", v), mif.move_ready, 1'b1);
        end

        // game over blocks new acceptances
        @(negedge clk);
        juego_terminado = 1'b1;
        #1;
        check("jt.ready", mif.move_ready, 1'b0);
        mif.move_valid = 1'b1;
        mif.move_col   = 3'd2;
        pulses = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            pulses += int'(move_done) + int'(move_reject);
        end
        mif.move_valid = 1'b0;
        check("jt.no_pulse", pulses, 0);
        check("jt.board", board, model_board);
        @(negedge clk);
        juego_terminado = 1'b0;

        // game over rising mid-move: the in-flight move still commits
        run_move("jt_mid", 3'd2, 1'b1, 2, 3'd5, 1'b1);
        check("jt_mid.ready", mif.move_ready, 1'b0);
        @(negedge clk);
        juego_terminado = 1'b0;

        // fill the whole board
        do_reset();
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                run_move($sformatf("fill_c%0d_n%0d", c, r), 3'(c), 1'b1, 2 + r, 3'(ROWS - 1 - r), 1'b0);
        check("full.lleno", tablero_lleno, 1'b1);
        check("full.ready", mif.move_ready, 1'b0);
        @(negedge clk);
        mif.move_valid = 1'b1;
        mif.move_col   = 3'd1;
        pulses = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            pulses += int'(move_done) + int'(move_reject);
        end
        mif.move_valid = 1'b0;
        check("full.no_pulse", pulses, 0);
        check("full.lleno_held", tablero_lleno, 1'b1);

        // reset during SCAN aborts the move
        do_reset();
        check("rst2.lleno", tablero_lleno, 1'b0);
        run_move("pre_scan", 3'd4, 1'b1, 2, 3'd5, 1'b0);
        @(negedge clk);
        mif.move_valid = 1'b1;
        mif.move_col   = 3'd4;
        @(posedge clk);
        #1;
        mif.move_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("scan_rst.board", board, '0);
        check("scan_rst.turn", turn, 1'b0);
        check("scan_rst.pulses", {move_done, move_reject}, 2'b00);
        rst = 1'b0;
        model_board = '0;
        model_turn  = 1'b0;
        @(negedge clk);
        check("scan_rst.ready", mif.move_ready, 1'b1);
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            pulses += int'(move_done) + int'(move_reject);
        end
        check("scan_rst.no_pulse", pulses, 0);
        run_move("post_rst", 3'd4, 1'b1, 2, 3'd5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
